epp_panel_driver: RTL and testbench

- Top-level e-paper panel (EPP) refresh engine for a 950x540 electrophoretic panel on an Artix-7 board.
- Sequences panel power, gate driver (SPV/CKV) and 8-bit source driver (SPH/CL/LE/OE) to write full-screen frames.
- Runs one refresh automatically after reset; the black button starts further refreshes with an alternating pattern.

---
 rtl/epp_pkg.sv | 43 ++++
 rtl/epp_panel_driver_btn_sync.sv | 48 ++++
 rtl/epp_panel_driver.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_epp_panel_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/epp_pkg.sv
// -----------------------------------------------------------------------------
// epp_pkg
// Shared definitions for the e-paper panel refresh engine:
//   - epp_state_e    : refresh sequencer states
//   - PIX_*          : 2-bit source driver pixel codes
//   - epp_build_byte : builds one 4-pixel source byte, padding pixels that lie
//                      beyond the physical line width with the no-op code
// -----------------------------------------------------------------------------
package epp_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PWR_UP      = 3'd1,
    FRAME_START = 3'd2,
    LINE_SHIFT  = 3'd3,
    LINE_LATCH  = 3'd4,
    FRAME_END   = 3'd5,
    PWR_DOWN    = 3'd6
  } epp_state_e;

  localparam logic [1:0] PIX_WHITE = 2'b10;
  localparam logic [1:0] PIX_BLACK = 2'b01;
  localparam logic [1:0] PIX_NOP   = 2'b00;

  // Pixel 0 of the byte sits in bits [1:0]; pixels at or past h_pix are no-ops.
  function automatic logic [7:0] epp_build_byte(input logic        pattern,
                                                input int unsigned byte_idx,
                                                input int unsigned h_pix);
    logic [7:0]  b;
    int unsigned pix_idx;
    b = 8'h00;
    for (int unsigned p = 32'd0; p < 32'd4; p++) begin
      pix_idx = byte_idx * 32'd4 + p;
      if (pix_idx < h_pix) begin
        b[2*p +: 2] = pattern ? PIX_BLACK : PIX_WHITE;
      end else begin
        b[2*p +: 2] = PIX_NOP;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/epp_panel_driver_btn_sync.sv
// -----------------------------------------------------------------------------
// epp_btn_sync
// Two-flop synchronizer for an asynchronous push button followed by a
// rising-edge detector producing a registered one-cycle pulse.
// Ports:
//   clk        in  system clock
//   nrst       in  synchronous active-low reset
//   btn_async  in  raw button level, active high
//   rise_pulse out one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module epp_btn_sync (
  input  logic clk,
  input  logic nrst,
  input  logic btn_async,
  output logic rise_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic rise_q,  rise_d;

  // Next-state: shift the synchronizer and flag a low-to-high transition.
  always_comb begin
    sync1_d = btn_async;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_pulse = rise_q;

endmodule

// File: rtl/epp_panel_driver.sv
// -----------------------------------------------------------------------------
// epp_panel_driver
// Full-screen refresh engine for an electrophoretic panel. Sequences panel
// power, the gate driver (SPV/CKV) and the 8-bit source driver (SPH/CL/LE/OE).
// One refresh runs after reset; each black-button press while idle toggles
// the pattern (white/black) and starts another refresh.
// Build option: define EPP_IBUFDS_EN to route the differential clock through
// an IBUFDS; otherwise sys_clk_p is the clock and sys_clk_n is unused.
// Ports:
//   sys_clk_p/n  in  differential system clock
//   sys_nrst     in  synchronous active-low reset
//   btn_black    in  asynchronous push button, active high
//   epd_*        out panel control/data (all registered)
//   busy         out refresh in progress
// -----------------------------------------------------------------------------
module epp_panel_driver
  import epp_pkg::*;
#(
  parameter int unsigned H_PIX    = 950,
  parameter int unsigned V_LINES  = 540,
  parameter int unsigned N_FRAMES = 10,
  parameter int unsigned CLK_DIV  = 10,
  parameter int unsigned PWR_DLY  = 200000,
  parameter int unsigned PULSE_W  = 20
) (
  input  logic       sys_clk_p,
  input  logic       sys_clk_n,
  input  logic       sys_nrst,
  input  logic       btn_black,
  output logic       epd_pwr_en,
  output logic       epd_gmode,
  output logic       epd_spv,
  output logic       epd_ckv,
  output logic       epd_sph,
  output logic       epd_cl,
  output logic       epd_le,
  output logic       epd_oe,
  output logic [7:0] epd_data,
  output logic       busy
);

  localparam int unsigned H_BYTES   = (H_PIX + 32'd3) / 32'd4;
  localparam int unsigned CNT_MAX_A = (PWR_DLY > 32'd2 * PULSE_W) ? PWR_DLY : 32'd2 * PULSE_W;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > CLK_DIV) ? CNT_MAX_A : CLK_DIV;
  localparam int unsigned CNT_W     = (CNT_MAX  > 32'd1) ? $clog2(CNT_MAX)  : 32'd1;
  localparam int unsigned BYTE_W    = (H_BYTES  > 32'd1) ? $clog2(H_BYTES)  : 32'd1;
  localparam int unsigned LINE_W    = (V_LINES  > 32'd1) ? $clog2(V_LINES)  : 32'd1;
  localparam int unsigned FRAME_W   = (N_FRAMES > 32'd1) ? $clog2(N_FRAMES) : 32'd1;

  localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   PWR_LAST   = CNT_W'(PWR_DLY - 32'd1);
  localparam logic [CNT_W-1:0]   PW_LAST    = CNT_W'(PULSE_W - 32'd1);
  localparam logic [CNT_W-1:0]   LATCH_LAST = CNT_W'(32'd2 * PULSE_W - 32'd1);
  localparam logic [CNT_W-1:0]   DIV_LAST   = CNT_W'(CLK_DIV - 32'd1);
  localparam logic [CNT_W-1:0]   DIV_HALF   = CNT_W'(CLK_DIV / 32'd2);
  localparam logic [BYTE_W-1:0]  BYTE_LAST  = BYTE_W'(H_BYTES - 32'd1);
  localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(V_LINES - 32'd1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(N_FRAMES - 32'd1);

  logic clk;

`ifdef EPP_IBUFDS_EN
  IBUFDS u_clk_ibufds (
    .I  (sys_clk_p),
    .IB (sys_clk_n),
    .O  (clk)
  );
`else
  logic unused_clk_n_s;
  assign clk            = sys_clk_p;
  assign unused_clk_n_s = sys_clk_n;
`endif

  logic btn_rise_s;

  epp_btn_sync u_btn_sync (
    .clk        (clk),
    .nrst       (sys_nrst),
    .btn_async  (btn_black),
    .rise_pulse (btn_rise_s)
  );

  epp_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic pwr_en_q, pwr_en_d, gmode_q, gmode_d, spv_q, spv_d, ckv_q, ckv_d;
  logic sph_q, sph_d, cl_q, cl_d, le_q, le_d, oe_q, oe_d;
  logic busy_q, busy_d, pattern_q, pattern_d, start_pending_q, start_pending_d;
  logic [7:0] data_q, data_d;

  // Sequencer next-state and next-output logic. Outputs are decided on the
  // edge that enters a phase, so the registered pins line up with the state.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    byte_d          = byte_q;
    line_d          = line_q;
    frame_d         = frame_q;
    pwr_en_d        = pwr_en_q;
    gmode_d         = gmode_q;
    spv_d           = spv_q;
    ckv_d           = ckv_q;
    sph_d           = sph_q;
    cl_d            = cl_q;
    le_d            = le_q;
    oe_d            = oe_q;
    data_d          = data_q;
    busy_d          = busy_q;
    pattern_d       = pattern_q;
    start_pending_d = start_pending_q;

    case (state_q)
      IDLE: begin
        if (start_pending_q) begin
          start_pending_d = 1'b0;
          busy_d          = 1'b1;
          pwr_en_d        = 1'b1;
          cnt_d           = CNT_ZERO;
          state_d         = PWR_UP;
        end else begin
          busy_d = 1'b0;
        end
      end
      PWR_UP: begin
        if (cnt_q == PWR_LAST) begin
          oe_d    = 1'b1;
          gmode_d = 1'b1;
          spv_d   = 1'b0;   // SPV low and the start-of-frame CKV pulse coincide
          ckv_d   = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = FRAME_START;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      FRAME_START: begin
        if (cnt_q == PW_LAST) begin
          spv_d   = 1'b1;
          ckv_d   = 1'b0;
          sph_d   = 1'b0;
          cl_d    = 1'b0;
          byte_d  = {BYTE_W{1'b0}};
          cnt_d   = CNT_ZERO;
          data_d  = epp_build_byte(pattern_q, 32'd0, H_PIX);
          state_d = LINE_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LINE_SHIFT: begin
        // cnt walks one CL period; the byte only changes where cl returns low.
        if (cnt_q == DIV_LAST) begin
          cnt_d = CNT_ZERO;
          cl_d  = 1'b0;
          if (byte_q == BYTE_LAST) begin
            sph_d   = 1'b1;
            data_d  = 8'h00;
            le_d    = 1'b1;
            state_d = LINE_LATCH;
          end else begin
            byte_d = byte_q + BYTE_W'(1);
            data_d = epp_build_byte(pattern_q, 32'(byte_q) + 32'd1, H_PIX);
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          cl_d  = (cnt_d >= DIV_HALF);
        end
      end
      LINE_LATCH: begin
        // First PULSE_W cycles: LE high. Next PULSE_W cycles: CKV high.
        if (cnt_q == PW_LAST) begin
          le_d  = 1'b0;
          ckv_d = 1'b1;
          cnt_d = cnt_q + CNT_ONE;
        end else if (cnt_q == LATCH_LAST) begin
          ckv_d = 1'b0;
          cnt_d = CNT_ZERO;
          if (line_q == LINE_LAST) begin
            line_d  = {LINE_W{1'b0}};
            state_d = FRAME_END;
          end else begin
            line_d  = line_q + LINE_W'(1);
            sph_d   = 1'b0;
            cl_d    = 1'b0;
            byte_d  = {BYTE_W{1'b0}};
            data_d  = epp_build_byte(pattern_q, 32'd0, H_PIX);
            state_d = LINE_SHIFT;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      FRAME_END: begin
        cnt_d = CNT_ZERO;
        if (frame_q == FRAME_LAST) begin
          frame_d = {FRAME_W{1'b0}};
          oe_d    = 1'b0;
          gmode_d = 1'b0;
          state_d = PWR_DOWN;
        end else begin
          frame_d = frame_q + FRAME_W'(1);
          spv_d   = 1'b0;
          ckv_d   = 1'b1;
          state_d = FRAME_START;
        end
      end
      PWR_DOWN: begin
        if (cnt_q == PWR_LAST) begin
          pwr_en_d = 1'b0;
          busy_d   = 1'b0;
          cnt_d    = CNT_ZERO;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // A press only counts while nothing is running or already queued.
    if (btn_rise_s && !busy_q && !start_pending_q) begin
      pattern_d       = ~pattern_q;
      start_pending_d = 1'b1;
    end else begin
      pattern_d = pattern_q;
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge clk) begin
    if (!sys_nrst) begin
      state_q         <= IDLE;
      cnt_q           <= CNT_ZERO;
      byte_q          <= {BYTE_W{1'b0}};
      line_q          <= {LINE_W{1'b0}};
      frame_q         <= {FRAME_W{1'b0}};
      pwr_en_q        <= 1'b0;
      gmode_q         <= 1'b0;
      spv_q           <= 1'b1;
      ckv_q           <= 1'b0;
      sph_q           <= 1'b1;
      cl_q            <= 1'b0;
      le_q            <= 1'b0;
      oe_q            <= 1'b0;
      data_q          <= 8'h00;
      busy_q          <= 1'b0;
      pattern_q       <= 1'b0;
      start_pending_q <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      byte_q          <= byte_d;
      line_q          <= line_d;
      frame_q         <= frame_d;
      pwr_en_q        <= pwr_en_d;
      gmode_q         <= gmode_d;
      spv_q           <= spv_d;
      ckv_q           <= ckv_d;
      sph_q           <= sph_d;
      cl_q            <= cl_d;
      le_q            <= le_d;
      oe_q            <= oe_d;
      data_q          <= data_d;
      busy_q          <= busy_d;
      pattern_q       <= pattern_d;
      start_pending_q <= start_pending_d;
    end
  end

  assign epd_pwr_en = pwr_en_q;
  assign epd_gmode  = gmode_q;
  assign epd_spv    = spv_q;
  assign epd_ckv    = ckv_q;
  assign epd_sph    = sph_q;
  assign epd_cl     = cl_q;
  assign epd_le     = le_q;
  assign epd_oe     = oe_q;
  assign epd_data   = data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_epp_panel_driver.sv
// -----------------------------------------------------------------------------
// tb_epp_panel_driver
// Scoreboard bench for epp_panel_driver with a reduced panel geometry.
// Expected source bytes are queued when a refresh is started and popped on
// every CL rising edge; pulse counts and power timing are checked per refresh.
// -----------------------------------------------------------------------------
module tb_epp_panel_driver;

  localparam int unsigned H_PIX    = 6;
  localparam int unsigned V_LINES  = 3;
  localparam int unsigned N_FRAMES = 2;
  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned PWR_DLY  = 16;
  localparam int unsigned PULSE_W  = 2;

  logic       sys_clk_p = 1'b0;
  logic       sys_clk_n;
  logic       sys_nrst  = 1'b0;
  logic       btn_black = 1'b0;
  logic       epd_pwr_en, epd_gmode, epd_spv, epd_ckv, epd_sph;
  logic       epd_cl, epd_le, epd_oe, busy;
  logic [7:0] epd_data;

  assign sys_clk_n = ~sys_clk_p;
  always #5 sys_clk_p = ~sys_clk_p;

  epp_panel_driver #(
    .H_PIX    (H_PIX),
    .V_LINES  (V_LINES),
    .N_FRAMES (N_FRAMES),
    .CLK_DIV  (CLK_DIV),
    .PWR_DLY  (PWR_DLY),
    .PULSE_W  (PULSE_W)
  ) dut (
    .sys_clk_p  (sys_clk_p),
    .sys_clk_n  (sys_clk_n),
    .sys_nrst   (sys_nrst),
    .btn_black  (btn_black),
    .epd_pwr_en (epd_pwr_en),
    .epd_gmode  (epd_gmode),
    .epd_spv    (epd_spv),
    .epd_ckv    (epd_ckv),
    .epd_sph    (epd_sph),
    .epd_cl     (epd_cl),
    .epd_le     (epd_le),
    .epd_oe     (epd_oe),
    .epd_data   (epd_data),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb_q[$];

  int cyc = 0;
  int t_pwr_up = 0, t_oe_up = 0, t_oe_dn = 0, t_pwr_dn = 0;
  int spv_pulses = 0, le_pulses = 0, ckv_pulses = 0, cl_line = 0;
  int stab_viol = 0, data_viol = 0;
  logic p_spv, p_ckv, p_le, p_cl, p_sph, p_oe, p_pwr, p_busy;
  logic [7:0] p_data;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observes the outputs once per cycle (1 time unit after the rising edge).
  task automatic monitor();
    cyc++;
    if (busy && !p_busy) begin
      spv_pulses = 0;
      le_pulses  = 0;
      ckv_pulses = 0;
    end
    if (epd_pwr_en && !p_pwr) t_pwr_up = cyc;
    if (!epd_pwr_en && p_pwr) t_pwr_dn = cyc;
    if (epd_oe && !p_oe)      t_oe_up  = cyc;
    if (!epd_oe && p_oe)      t_oe_dn  = cyc;
    if (!epd_spv && p_spv)    spv_pulses++;
    if (epd_le && !p_le)      le_pulses++;
    if (epd_ckv && !p_ckv)    ckv_pulses++;
    if (!epd_sph && p_sph)    cl_line = 0;
    if (epd_cl && !p_cl) begin
      cl_line++;
      if (epd_sph) data_viol++;
      if (sb_q.size() == 0) check_val("sb_unexpected_cl", sb_q.size(), 1);
      else                  check_val("cl_data", 32'(epd_data), 32'(sb_q.pop_front()));
    end
    if (epd_sph && !p_sph && sys_nrst) check_val("cl_per_line", cl_line, 2);
    if (epd_sph && epd_data != 8'h00) data_viol++;
    if (epd_cl && epd_data != p_data) stab_viol++;
    p_spv = epd_spv; p_ckv = epd_ckv; p_le = epd_le; p_cl = epd_cl;
    p_sph = epd_sph; p_oe = epd_oe; p_pwr = epd_pwr_en; p_busy = busy;
    p_data = epd_data;
  endtask

  task automatic step();
    @(posedge sys_clk_p);
    #1;
    monitor();
  endtask

  task automatic push_refresh(input logic pat);
    for (int f = 0; f < int'(N_FRAMES); f++) begin
      for (int l = 0; l < int'(V_LINES); l++) begin
        sb_q.push_back(pat ? 8'h55 : 8'hAA);
        sb_q.push_back(pat ? 8'h05 : 8'h0A);
      end
    end
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      step();
      n++;
    end
    check_val(tag, 32'(busy), 32'(lvl));
  endtask

  task automatic press_btn();
    btn_black = 1'b1;
    repeat (5) step();
    btn_black = 1'b0;
  endtask

  task automatic check_refresh();
    check_val("spv_pulses", spv_pulses, int'(N_FRAMES));
    check_val("le_pulses", le_pulses, int'(N_FRAMES * V_LINES));
    check_val("ckv_pulses", ckv_pulses, int'(N_FRAMES * (V_LINES + 1)));
    check_val("pwr_to_oe", t_oe_up - t_pwr_up, int'(PWR_DLY));
    check_val("oe_to_pwr_off", t_pwr_dn - t_oe_dn, int'(PWR_DLY));
    check_val("sb_left", sb_q.size(), 0);
    check_val("pwr_off", 32'(epd_pwr_en), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val(tag, 32'({epd_pwr_en, epd_gmode, epd_spv, epd_ckv, epd_sph,
                        epd_cl, epd_le, epd_oe, busy}), 32'(9'b001010000));
    check_val("rst_data", 32'(epd_data), 0);
  endtask

  initial begin
    int n;
    // Reset state, then the automatic pattern-0 refresh.
    repeat (3) step();
    check_reset_outs("rst_outs");
    push_refresh(1'b0);
    sys_nrst = 1'b1;
    wait_busy(1'b1, 10, "auto_start");
    wait_busy(1'b0, 2000, "auto_done");
    check_refresh();

    // Button press while idle: pattern 1 refresh.
    repeat (10) step();
    push_refresh(1'b1);
    press_btn();
    wait_busy(1'b1, 20, "btn_start");
    wait_busy(1'b0, 2000, "btn_done");
    check_refresh();

    // Press during a refresh must be ignored.
    repeat (10) step();
    push_refresh(1'b0);
    press_btn();
    wait_busy(1'b1, 20, "btn2_start");
    repeat (30) step();
    press_btn();
    wait_busy(1'b0, 2000, "btn2_done");
    check_refresh();
    repeat (60) step();
    check_val("no_extra_refresh", 32'(busy), 0);

    // Next press must give pattern 1, then reset lands mid LINE_SHIFT.
    push_refresh(1'b1);
    press_btn();
    wait_busy(1'b1, 20, "btn3_start");
    n = 0;
    while (!(epd_sph == 1'b0 && epd_cl == 1'b1) && n < 200) begin
      step();
      n++;
    end
    check_val("reach_shift", 32'(epd_sph), 0);
    sys_nrst = 1'b0;
    step();
    check_reset_outs("midrst_outs");
    sb_q.delete();
    repeat (3) step();
    push_refresh(1'b0);
    sys_nrst = 1'b1;
    wait_busy(1'b1, 10, "rst_restart");
    wait_busy(1'b0, 2000, "rst_done");
    check_refresh();

    check_val("data_stable_cl_high", stab_viol, 0);
    check_val("data_outside_shift", data_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
